// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// master = control FSM, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       halt;
   logic       mem_req;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;
   logic       pc_en;
   logic       instr_done;
   logic       illegal_op;
   logic       mem_timeout;

   modport master (
      input  opcode, funct, zero, mem_ready, halt,
      output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
      output RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc,
      output pc_en, instr_done, illegal_op, mem_timeout
   );

   modport slave (
      output opcode, funct, zero, mem_ready, halt,
      input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
      input  RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc,
      input  pc_en, instr_done, illegal_op, mem_timeout
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath with a shared memory
// and a watchdog that traps into ERROR when memory never answers.
module multicycle_ctrl_fsm #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_ctrl_fsm_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
      ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j;
   logic       r_ok;
   logic [2:0] r_alu;
   logic       req, stall, expired;
   logic       pcwrite, branch;

   assign is_r    = bus.opcode == 6'b000000;
   assign is_lw   = bus.opcode == 6'b100011;
   assign is_sw   = bus.opcode == 6'b101011;
   assign is_beq  = bus.opcode == 6'b000100;
   assign is_addi = bus.opcode == 6'b001000;
   assign is_j    = bus.opcode == 6'b000010;

   always_comb begin
      r_ok  = 1'b1;
      r_alu = 3'b000;
      case (bus.funct)
         6'b100000: r_alu = 3'b010;
         6'b100010: r_alu = 3'b110;
         6'b100100: r_alu = 3'b000;
         6'b100101: r_alu = 3'b001;
         6'b101010: r_alu = 3'b111;
         default:   r_ok  = 1'b0;
      endcase
   end

   // Watchdog only runs while a request is outstanding and unanswered;
   // a ready on the last allowed cycle still completes the access.
   assign req = (state_q == FETCH && !bus.halt) ||
                state_q == MEMRD || state_q == MEMWR;
   assign stall   = req && !bus.mem_ready;
   assign expired = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d   = stall ? cnt_q + CW'(1) : '0;
      state_d = state_q;
      unique case (state_q)
         FETCH:  if (req && bus.mem_ready) state_d = DECODE;
         DECODE: begin
            unique case (1'b1)
               is_lw, is_sw:  state_d = MEMADR;
               is_r && r_ok:  state_d = EXEC;
               is_beq:        state_d = BRANCH;
               is_addi:       state_d = ADDIEX;
               is_j:          state_d = JUMP;
               default:       state_d = FETCH;
            endcase
         end
         MEMADR: state_d = is_lw ? MEMRD : (is_sw ? MEMWR : FETCH);
         MEMRD:  if (bus.mem_ready) state_d = MEMWB;
         MEMWR:  if (bus.mem_ready) state_d = FETCH;
         EXEC:   state_d = ALUWB;
         ADDIEX: state_d = ADDIWB;
         ERROR:  state_d = ERROR;
         default: state_d = FETCH;
      endcase
      if (expired) state_d = ERROR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.mem_req     = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegDst      = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUControl  = 3'b000;
      bus.PCSrc       = 2'b00;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
      pcwrite         = 1'b0;
      branch          = 1'b0;
      if (!rst) begin
         unique case (state_q)
            FETCH: if (!bus.halt) begin
               bus.mem_req    = 1'b1;
               bus.ALUSrcB    = 2'b01;
               bus.ALUControl = 3'b010;
               bus.IRWrite    = bus.mem_ready;
               pcwrite        = bus.mem_ready;
            end
            DECODE: begin
               bus.ALUSrcB    = 2'b11;
               bus.ALUControl = 3'b010;
               bus.illegal_op = !(is_lw || is_sw || is_beq ||
                                  is_addi || is_j || (is_r && r_ok));
            end
            MEMADR, ADDIEX: begin
               bus.ALUSrcA    = 1'b1;
               bus.ALUSrcB    = 2'b10;
               bus.ALUControl = 3'b010;
            end
            MEMRD: begin
               bus.mem_req = 1'b1;
               bus.IorD    = 1'b1;
            end
            MEMWB: begin
               bus.MemtoReg   = 1'b1;
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            MEMWR: begin
               bus.mem_req    = 1'b1;
               bus.IorD       = 1'b1;
               bus.MemWrite   = 1'b1;
               bus.instr_done = bus.mem_ready;
            end
            EXEC: begin
               bus.ALUSrcA    = 1'b1;
               bus.ALUControl = r_alu;
            end
            ALUWB: begin
               bus.RegDst     = 1'b1;
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            BRANCH: begin
               bus.ALUSrcA    = 1'b1;
               bus.ALUControl = 3'b110;
               bus.PCSrc      = 2'b01;
               branch         = 1'b1;
               bus.instr_done = 1'b1;
            end
            ADDIWB: begin
               bus.RegWrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            JUMP: begin
               bus.PCSrc      = 2'b10;
               pcwrite        = 1'b1;
               bus.instr_done = 1'b1;
            end
            ERROR: bus.mem_timeout = 1'b1;
            default: ;
         endcase
      end
      bus.pc_en = pcwrite | (branch & bus.zero);
   end
endmodule
